// File: rtl/mem_loader.sv
// Framed byte-stream loader: parses ADDR/CNT header, packs 16-bit words and
// drives the data-memory write port, then reports completion and checksum status.
module mem_loader #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_wr_en,
  output logic [p_ADDR_LEN-1:0] o_addr,
  output logic [p_WORD_LEN-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_ADDR_HI = 3'd0,
    S_ADDR_LO = 3'd1,
    S_CNT_HI  = 3'd2,
    S_CNT_LO  = 3'd3,
    S_DATA_HI = 3'd4,
    S_DATA_LO = 3'd5,
    S_SUM     = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  function automatic logic [7:0] sum_upd(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                state_q, state_d;
  logic [7:0]            hdr_hi_q, hdr_hi_d;
  logic [p_ADDR_LEN-1:0] addr_q, addr_d;
  logic [15:0]           remain_q, remain_d;
  logic [7:0]            data_hi_q, data_hi_d;
  logic [7:0]            sum_q, sum_d;
  logic                  wr_en_q, wr_en_d;
  logic [p_ADDR_LEN-1:0] wr_addr_q, wr_addr_d;
  logic [p_WORD_LEN-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept_s;

  assign o_rx_ready = i_rst_n && (state_q != S_DONE);
  assign accept_s   = i_rx_valid && o_rx_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_ADDR_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one byte per state, S_DONE lasts a single cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ADDR_HI: if (accept_s) state_d = S_ADDR_LO; else state_d = state_q;
      S_ADDR_LO: if (accept_s) state_d = S_CNT_HI;  else state_d = state_q;
      S_CNT_HI:  if (accept_s) state_d = S_CNT_LO;  else state_d = state_q;
      S_CNT_LO: begin
        if (accept_s) begin
          state_d = ({hdr_hi_q, i_rx_data} != 16'd0) ? S_DATA_HI : S_SUM;
        end else begin
          state_d = state_q;
        end
      end
      S_DATA_HI: if (accept_s) state_d = S_DATA_LO; else state_d = state_q;
      S_DATA_LO: begin
        if (accept_s) begin
          state_d = (remain_q != 16'd1) ? S_DATA_HI : S_SUM;
        end else begin
          state_d = state_q;
        end
      end
      S_SUM:   if (accept_s) state_d = S_DONE; else state_d = state_q;
      S_DONE:  state_d = S_ADDR_HI;
      default: state_d = S_ADDR_HI;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    hdr_hi_d  = hdr_hi_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    data_hi_d = data_hi_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    busy_d    = (state_d != S_ADDR_HI);
    done_d    = (state_d == S_DONE);
    if (accept_s) begin
      case (state_q)
        S_ADDR_HI: begin
          hdr_hi_d = i_rx_data;
          sum_d    = 8'h00;
        end
        S_ADDR_LO: addr_d   = p_ADDR_LEN'({hdr_hi_q, i_rx_data});
        S_CNT_HI:  hdr_hi_d = i_rx_data;
        S_CNT_LO:  remain_d = {hdr_hi_q, i_rx_data};
        S_DATA_HI: begin
          data_hi_d = i_rx_data;
          sum_d     = sum_upd(sum_q, i_rx_data);
        end
        S_DATA_LO: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {data_hi_q, i_rx_data};
          addr_d    = addr_q + p_ADDR_LEN'(1'b1);
          remain_d  = remain_q - 16'd1;
          sum_d     = sum_upd(sum_q, i_rx_data);
        end
        S_SUM:   err_d = (sum_q != i_rx_data);
        default: wr_en_d = 1'b0;
      endcase
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hdr_hi_q  <= 8'h00;
      addr_q    <= '0;
      remain_q  <= 16'd0;
      data_hi_q <= 8'h00;
      sum_q     <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hdr_hi_q  <= hdr_hi_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      data_hi_q <= data_hi_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_addr    = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: directed and random frames, expected writes
// and checksum outcomes queued by a frame-level model, checked by a monitor.
module tb_mem_loader;

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_wr_en;
  logic [9:0]  o_addr;
  logic [15:0] o_wr_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  mem_loader #(.p_WORD_LEN(16), .p_ADDR_LEN(10)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_rx_ready(o_rx_ready), .o_wr_en(o_wr_en), .o_addr(o_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_wr_q[$];
  bit          exp_err_q[$];
  logic [15:0] words_q[$];
  int          tests = 0;
  int          fails = 0;
  int          ready_low_cnt = 0;
  bit          model_err = 1'b0;
  bit          prev_wr = 1'b0;
  bit          prev_done = 1'b0;
  wr_t         mon_w;
  bit          mon_e;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and frame outcomes when the DUT presents them
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (!o_rx_ready) ready_low_cnt++;
      if (o_wr_en) begin
        check("no_back_to_back_wr", 32'(prev_wr), 32'd0);
        check("wr_busy", 32'(o_busy), 32'd1);
        if (exp_wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %0h@%0h expected none", o_wr_data, o_addr);
        end else begin
          mon_w = exp_wr_q.pop_front();
          check("wr_addr", 32'(o_addr), 32'(mon_w.a));
          check("wr_data", 32'(o_wr_data), 32'(mon_w.d));
        end
      end
      if (o_done) begin
        check("done_ready_low", 32'(o_rx_ready), 32'd0);
        check("done_busy", 32'(o_busy), 32'd1);
        if (exp_err_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          mon_e = exp_err_q.pop_front();
          check("done_err", 32'(o_err), 32'(mon_e));
          model_err = mon_e;
        end
      end else begin
        check("err_sticky", 32'(o_err), 32'(model_err));
      end
      if (prev_done) check("busy_fall", 32'(o_busy), 32'd0);
      prev_wr   = o_wr_en;
      prev_done = o_done;
    end else begin
      prev_wr   = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      i_rx_valid = 1'b0;
      i_rx_data  = 8'($urandom);
      @(posedge i_clk); #1;
    end
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    n = 0;
    while (!o_rx_ready && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=0 for %0d cycles expected 1", n);
    end else begin
      @(posedge i_clk); #1;
    end
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  // Frame-level model: address = start + index mod 1024, checksum = XOR of data bytes
  task automatic send_frame(input logic [15:0] a, input int gap, input bit bad);
    logic [7:0]  s;
    logic [15:0] cnt;
    int          rl0;
    wr_t         w;
    s   = 8'h00;
    rl0 = ready_low_cnt;
    cnt = 16'(words_q.size());
    for (int i = 0; i < words_q.size(); i++) begin
      s   = s ^ words_q[i][15:8] ^ words_q[i][7:0];
      w.a = a[9:0] + 10'(i);
      w.d = words_q[i];
      exp_wr_q.push_back(w);
    end
    if (bad) s = s ^ 8'($urandom_range(1, 255));
    exp_err_q.push_back(bad);
    send_byte(a[15:8], gap);
    send_byte(a[7:0], gap);
    send_byte(cnt[15:8], gap);
    send_byte(cnt[7:0], gap);
    for (int i = 0; i < words_q.size(); i++) begin
      send_byte(words_q[i][15:8], gap);
      send_byte(words_q[i][7:0], gap);
    end
    send_byte(s, gap);
    @(posedge i_clk); #1;
    check("ready_low_once_per_frame", 32'(ready_low_cnt - rl0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
    check({tag, "_addr"}, 32'(o_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
  endtask

  initial begin
    int n;
    i_rst_n    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    check("reset_ready", 32'(o_rx_ready), 32'd0);
    i_rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(o_rx_ready), 32'd1);

    words_q = '{16'hABCD, 16'h1234};
    send_frame(16'h0010, 0, 1'b0);
    send_frame(16'h0010, 0, 1'b1);
    send_frame(16'h0010, 0, 1'b0);
    words_q.delete();
    send_frame(16'h0005, 0, 1'b0);
    words_q = '{16'h0001, 16'h0002};
    send_frame(16'hFFFF, 0, 1'b0);
    words_q = '{16'hABCD, 16'h1234};
    send_frame(16'h0010, 3, 1'b0);

    // Bad frame leaves err set, then a frame aborted by reset after word 1 HI byte
    send_frame(16'h0010, 1, 1'b1);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAB, 0);
    i_rst_n = 1'b0;
    #1;
    check("midreset_ready", 32'(o_rx_ready), 32'd0);
    @(posedge i_clk); #1;
    check_all_zero("midreset");
    model_err = 1'b0;
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("midreset_no_write", 32'(o_wr_en), 32'd0);
    send_frame(16'h0010, 0, 1'b0);

    for (int f = 0; f < 20; f++) begin
      n = int'($urandom_range(0, 6));
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
      send_frame(16'($urandom), int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge i_clk);
    #1;
    check("pending_writes", 32'(exp_wr_q.size()), 32'd0);
    check("pending_frames", 32'(exp_err_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
